demux_1to4_reg: RTL and testbench
=================================

# demux_1to4_reg

Registered 1-to-4 stream demultiplexer, the inverse of the team's 4-to-1 mux: one input word stream is steered to one of four output channels (a, b, c, d) by the 2-bit select {s1,s0}. Each output channel has a one-entry holding register with valid/ready handshake, so a stalled channel never blocks the other three. Per-channel 8-bit delivery counters support lab-board debug displays and bench scoreboarding. The block sits between a single producer and four independent consumers.

## Interface
- WIDTH, 8, data width of input and every output channel
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  WIDTH  word to route
- in_valid  input  1  in_data, s0, s1 valid this cycle
- in_ready  output  1  block accepts the word this cycle
- s0  input  1  select LSB
- s1  input  1  select MSB; {s1,s0}: 00→a, 01→b, 10→c, 11→d
- out_a / out_b / out_c / out_d  output  WIDTH  channel data registers
- valid_a / valid_b / valid_c / valid_d  output  1  channel holds a word
- ready_a / ready_b / ready_c / ready_d  input  1  consumer takes the channel word this cycle
- cnt_a / cnt_b / cnt_c / cnt_d  output  8  words delivered on each channel, mod 256

## Operation
- Channel x is selected when {s1,s0} equals x's code. s0/s1 are sampled only when in_valid=1.
- Input handshake: the word is accepted when in_valid & in_ready.
- in_ready is combinational: in_ready = ~valid_x | ready_x for the selected x. It depends only on the selected channel.
- Accept into channel x: out_x ← in_data and valid_x ← 1 on the next edge.
- Output handshake: channel x drains when valid_x & ready_x. On that edge cnt_x increments, wrapping 255→0.
- Drain with no refill: valid_x ← 0 and out_x holds its last value.
- Drain and refill in the same cycle: valid_x stays 1, out_x takes the new word, and cnt_x increments by exactly 1.
- Unselected channels are unaffected by input activity and drain independently. Up to four channels can drain in one cycle.
- No word is ever dropped or duplicated. A stalled channel backpressures only words selected to it.
- out_x is stable while valid_x=1 and ready_x=0.
- Per-channel state is two states, EMPTY (valid_x=0) and FULL (valid_x=1):
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept.
  - FULL→FULL on drain+accept, or on stall.
- Reset (asynchronous, any time) forces all out_x=0, valid_x=0, cnt_x=0 immediately. Buffered words are discarded.
- in_ready is 1 whenever rst is deasserted and the selected channel is empty, including the first cycle after reset.

## Timing
- Input-to-output latency: 1 clock. A word accepted at edge N is visible on out_x/valid_x after edge N.
- Throughput: one word per clock to any one channel. A continuously ready consumer sustains full rate.
- Counter update: cnt_x reflects a drain after the edge on which the drain occurs.
- in_ready has a combinational path from ready_x and s1/s0. There is no path from in_data to any output within a cycle.
- Reset release must meet recovery/removal relative to clk. Outputs stay at reset values until the first active edge after release.

## Test plan
- Reset and basic routing:
  - Assert rst mid-run → all valid_x=0, out_x=0, cnt_x=0 asynchronously.
  - Release rst, drive in_data=8'hA5, sel=10, in_valid=1, ready_c=1 → in_ready=1, then out_c=A5 and valid_c=1 one cycle later.
  - Next edge → valid_c=0, cnt_c=1.
- Routing sweep: send 11,22,33,44 with sel 00,01,10,11 on consecutive cycles, all ready=1 → each appears only on a,b,c,d respectively, one cycle after acceptance. Final counts are 1,1,1,1.
- Backpressure isolation:
  - ready_b=0 with channel b full; offer a sel=01 word → in_ready=0 and out_b is unchanged.
  - Same cycle, switch to sel=00 with word 5A → accepted, and out_a=5A next cycle.
- Drain+refill: channel d full with 01 and ready_d=1; offer 02 with sel=11 → valid_d stays 1, out_d=02, cnt_d increments by 1.
- Counter wrap: stream 257 words to channel a at full rate → cnt_a reads 255 then 0 then 1, with no in_ready bubbles.
- Reset mid-operation: all four channels full with consumers stalled; pulse rst between edges → valid_x drop immediately. After release, the first accepted word routes correctly and the counters restart from 0.

Source files
------------

// File: rtl/demux_1to4_reg_if.sv
// Stream bus for the 1-to-4 registered demux: one producer port,
// four consumer channels with valid/ready and delivery counters.
interface demux_1to4_reg_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             s0;
  logic             s1;

  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d;

  logic             valid_a;
  logic             valid_b;
  logic             valid_c;
  logic             valid_d;

  logic             ready_a;
  logic             ready_b;
  logic             ready_c;
  logic             ready_d;

  logic [7:0]       cnt_a;
  logic [7:0]       cnt_b;
  logic [7:0]       cnt_c;
  logic [7:0]       cnt_d;

  modport master (
    output in_data, in_valid, s0, s1,
    output ready_a, ready_b, ready_c, ready_d,
    input  in_ready,
    input  out_a, out_b, out_c, out_d,
    input  valid_a, valid_b, valid_c, valid_d,
    input  cnt_a, cnt_b, cnt_c, cnt_d
  );

  modport slave (
    input  in_data, in_valid, s0, s1,
    input  ready_a, ready_b, ready_c, ready_d,
    output in_ready,
    output out_a, out_b, out_c, out_d,
    output valid_a, valid_b, valid_c, valid_d,
    output cnt_a, cnt_b, cnt_c, cnt_d
  );
endinterface

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 stream demux: one holding register per channel,
// so a stalled consumer only blocks words routed to it.
module demux_1to4_reg #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  demux_1to4_reg_if.slave    bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           st_q   [4];
  state_e           st_d   [4];
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [7:0]       cnt_q  [4];
  logic [7:0]       cnt_d  [4];

  logic [1:0] sel;
  logic [3:0] rdy;
  logic [3:0] full;
  logic [3:0] acc;
  logic [3:0] drn;

  assign sel = {bus.s1, bus.s0};
  assign rdy = {bus.ready_d, bus.ready_c,
                bus.ready_b, bus.ready_a};

  // A full slot can take a new word in the cycle it drains.
  assign bus.in_ready = ~full[sel] | rdy[sel];

  assign drn = full & rdy;

  always_comb begin
    acc = '0;
    if (bus.in_valid && bus.in_ready)
      acc[sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        st_q[i]   <= EMPTY;
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        st_q[i]   <= st_d[i];
        data_q[i] <= data_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      st_d[i]   = st_q[i];
      data_d[i] = data_q[i];
      cnt_d[i]  = cnt_q[i] + {7'd0, drn[i]};
      unique case (st_q[i])
        EMPTY: if (acc[i]) st_d[i] = FULL;
        FULL:  if (drn[i] && !acc[i]) st_d[i] = EMPTY;
        default: st_d[i] = EMPTY;
      endcase
      if (acc[i])
        data_d[i] = bus.in_data;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++)
      full[i] = (st_q[i] == FULL);
  end

  assign bus.valid_a = full[0];
  assign bus.valid_b = full[1];
  assign bus.valid_c = full[2];
  assign bus.valid_d = full[3];

  assign bus.out_a = data_q[0];
  assign bus.out_b = data_q[1];
  assign bus.out_c = data_q[2];
  assign bus.out_d = data_q[3];

  assign bus.cnt_a = cnt_q[0];
  assign bus.cnt_b = cnt_q[1];
  assign bus.cnt_c = cnt_q[2];
  assign bus.cnt_d = cnt_q[3];

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Scoreboard bench for demux_1to4_reg: per-channel expected-word
// queues and counter model, checked every cycle on the falling edge.
module tb_demux_1to4_reg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   run = 1'b0;
  int   checks = 0;
  int   failures = 0;

  demux_1to4_reg_if #(.WIDTH(8)) ifc ();

  demux_1to4_reg #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  logic [7:0] dat [4];
  logic       vld [4];
  logic [7:0] cnt [4];
  logic       rdy [4];

  assign dat[0] = ifc.out_a;
  assign dat[1] = ifc.out_b;
  assign dat[2] = ifc.out_c;
  assign dat[3] = ifc.out_d;
  assign vld[0] = ifc.valid_a;
  assign vld[1] = ifc.valid_b;
  assign vld[2] = ifc.valid_c;
  assign vld[3] = ifc.valid_d;
  assign cnt[0] = ifc.cnt_a;
  assign cnt[1] = ifc.cnt_b;
  assign cnt[2] = ifc.cnt_c;
  assign cnt[3] = ifc.cnt_d;
  assign rdy[0] = ifc.ready_a;
  assign rdy[1] = ifc.ready_b;
  assign rdy[2] = ifc.ready_c;
  assign rdy[3] = ifc.ready_d;

  logic [7:0] q [4][$];
  logic [7:0] exp_cnt [4];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Model of the coming edge: compare state, then apply drain/accept.
  always @(negedge clk) begin : mon
    int   s;
    logic exp_rdy;
    if (run && !rst) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("valid%0d", i), 32'(vld[i]),
            32'(q[i].size() != 0));
        if (q[i].size() != 0)
          chk($sformatf("data%0d", i), 32'(dat[i]), 32'(q[i][0]));
        chk($sformatf("cnt%0d", i), 32'(cnt[i]), 32'(exp_cnt[i]));
      end
      s = int'({ifc.s1, ifc.s0});
      exp_rdy = (q[s].size() == 0) || rdy[s];
      if (ifc.in_valid)
        chk("in_ready", 32'(ifc.in_ready), 32'(exp_rdy));
      for (int i = 0; i < 4; i++) begin
        if (q[i].size() != 0 && rdy[i]) begin
          void'(q[i].pop_front());
          exp_cnt[i] = exp_cnt[i] + 8'd1;
        end
      end
      if (ifc.in_valid && exp_rdy)
        q[s].push_back(ifc.in_data);
    end
  end

  task automatic cyc(input logic v, input logic [1:0] s,
                     input logic [7:0] d, input logic [3:0] r);
    @(posedge clk);
    #1;
    ifc.in_valid = v;
    {ifc.s1, ifc.s0} = s;
    ifc.in_data = d;
    {ifc.ready_d, ifc.ready_c, ifc.ready_b, ifc.ready_a} = r;
  endtask

  task automatic clr_model();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      exp_cnt[i] = 8'd0;
    end
  endtask

  // Reset is raised and dropped between clock edges.
  task automatic pulse_rst();
    @(posedge clk);
    #3;
    ifc.in_valid = 1'b0;
    {ifc.ready_d, ifc.ready_c, ifc.ready_b, ifc.ready_a} = 4'b0;
    rst = 1'b1;
    clr_model();
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_valid%0d", i), 32'(vld[i]), 32'd0);
      chk($sformatf("rst_data%0d", i), 32'(dat[i]), 32'd0);
      chk($sformatf("rst_cnt%0d", i), 32'(cnt[i]), 32'd0);
    end
    #3;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'd0;
    ifc.s0 = 1'b0;
    ifc.s1 = 1'b0;
    {ifc.ready_d, ifc.ready_c, ifc.ready_b, ifc.ready_a} = 4'b0;
    clr_model();
    #1 rst = 1'b1;
    #2;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("init_valid%0d", i), 32'(vld[i]), 32'd0);
      chk($sformatf("init_cnt%0d", i), 32'(cnt[i]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    run = 1'b1;

    // Basic routing to c, then drain.
    cyc(1'b1, 2'b10, 8'hA5, 4'b0100);
    cyc(1'b0, 2'b10, 8'h00, 4'b0100);
    cyc(1'b0, 2'b00, 8'h00, 4'b0000);
    @(negedge clk); #1;
    chk("cnt_c_after_a5", 32'(ifc.cnt_c), 32'd1);

    // Routing sweep.
    pulse_rst();
    cyc(1'b1, 2'b00, 8'h11, 4'b1111);
    cyc(1'b1, 2'b01, 8'h22, 4'b1111);
    cyc(1'b1, 2'b10, 8'h33, 4'b1111);
    cyc(1'b1, 2'b11, 8'h44, 4'b1111);
    cyc(1'b0, 2'b00, 8'h00, 4'b1111);
    cyc(1'b0, 2'b00, 8'h00, 4'b1111);
    @(negedge clk); #1;
    chk("sweep_cnt_a", 32'(ifc.cnt_a), 32'd1);
    chk("sweep_cnt_b", 32'(ifc.cnt_b), 32'd1);
    chk("sweep_cnt_c", 32'(ifc.cnt_c), 32'd1);
    chk("sweep_cnt_d", 32'(ifc.cnt_d), 32'd1);

    // Backpressure isolation on b.
    cyc(1'b1, 2'b01, 8'h77, 4'b0000);
    cyc(1'b1, 2'b01, 8'h88, 4'b0000);
    @(negedge clk); #1;
    chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
    cyc(1'b1, 2'b00, 8'h5A, 4'b0000);
    cyc(1'b0, 2'b00, 8'h00, 4'b0000);
    @(negedge clk); #1;
    chk("bp_out_a", 32'(ifc.out_a), 32'h5A);
    chk("bp_out_b", 32'(ifc.out_b), 32'h77);
    cyc(1'b0, 2'b00, 8'h00, 4'b1111);

    // Drain and refill on d.
    cyc(1'b1, 2'b11, 8'h01, 4'b0000);
    cyc(1'b1, 2'b11, 8'h02, 4'b1000);
    cyc(1'b0, 2'b00, 8'h00, 4'b0000);
    @(negedge clk); #1;
    chk("refill_valid_d", 32'(ifc.valid_d), 32'd1);
    chk("refill_out_d", 32'(ifc.out_d), 32'h02);
    chk("refill_cnt_d", 32'(ifc.cnt_d), 32'd2);
    cyc(1'b0, 2'b00, 8'h00, 4'b1111);

    // Counter wrap on a at full rate.
    pulse_rst();
    for (int k = 0; k < 257; k++)
      cyc(1'b1, 2'b00, 8'(k), 4'b1111);
    cyc(1'b0, 2'b00, 8'h00, 4'b1111);
    cyc(1'b0, 2'b00, 8'h00, 4'b1111);
    @(negedge clk); #1;
    chk("wrap_cnt_a", 32'(ifc.cnt_a), 32'd1);

    // All channels full and stalled, then reset mid-operation.
    cyc(1'b1, 2'b00, 8'hA0, 4'b0000);
    cyc(1'b1, 2'b01, 8'hB0, 4'b0000);
    cyc(1'b1, 2'b10, 8'hC0, 4'b0000);
    cyc(1'b1, 2'b11, 8'hD0, 4'b0000);
    cyc(1'b0, 2'b00, 8'h00, 4'b0000);
    pulse_rst();
    cyc(1'b1, 2'b10, 8'hC3, 4'b1111);
    cyc(1'b0, 2'b00, 8'h00, 4'b1111);
    cyc(1'b0, 2'b00, 8'h00, 4'b1111);
    @(negedge clk); #1;
    chk("post_rst_cnt_c", 32'(ifc.cnt_c), 32'd1);
    chk("post_rst_cnt_a", 32'(ifc.cnt_a), 32'd0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("final_q%0d", i), 32'(q[i].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
